// File: rtl/bounce_pkg.sv
// Shared types, colour table and reset-state helpers for the bounce engine.
package bounce_pkg;

  localparam int POS_W = 9;
  localparam int VEL_W = 4;

  typedef logic [POS_W-1:0]        pos_t;
  typedef logic signed [VEL_W-1:0] vel_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } state_t;

  // RGB565 colour per ball index.
  localparam logic [15:0] COLOURS [8] = '{
    16'hF800, 16'h07E0, 16'h001F, 16'hFFE0,
    16'hF81F, 16'h07FF, 16'hFFFF, 16'hFD20
  };

  function automatic logic [15:0] colour_of(input logic [2:0] idx);
    return COLOURS[idx];
  endfunction

  function automatic pos_t init_x(input int i);
    return pos_t'(8 + 12 * i);
  endfunction

  function automatic pos_t init_y(input int i);
    return pos_t'(8 + 16 * i);
  endfunction

  function automatic vel_t init_vx(input int i);
    return (i % 2 == 0) ? vel_t'(2) : vel_t'(-1);
  endfunction

  function automatic vel_t init_vy(input int i);
    return (i % 2 == 0) ? vel_t'(1) : vel_t'(-2);
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// One-axis position step with wall reflection; pure combinational.
module bounce_axis
  import bounce_pkg::*;
#(
  parameter int LIMIT     = 128,
  parameter int BALL_SIZE = 4
) (
  input  pos_t pos,
  input  vel_t vel,
  output pos_t pos_next,
  output vel_t vel_next,
  output logic reflect
);

  localparam logic signed [POS_W:0] MAX_POS = (POS_W+1)'(LIMIT - BALL_SIZE);

  logic signed [POS_W:0] next;

  always_comb begin
    next     = $signed({1'b0, pos}) + $signed({{(POS_W+1-VEL_W){vel[VEL_W-1]}}, vel});
    pos_next = next[POS_W-1:0];
    vel_next = vel;
    reflect  = 1'b0;
    if (next <= 0) begin
      pos_next = '0;
      vel_next = -vel;
      reflect  = 1'b1;
    end else if (next >= MAX_POS) begin
      pos_next = MAX_POS[POS_W-1:0];
      vel_next = -vel;
      reflect  = 1'b1;
    end
  end

endmodule

// File: rtl/bounce_engine.sv
// Per-frame ball physics (one ball per clock after a vsync rise) plus a sprite pixel mux.
// Optional BOUNCE_ENGINE_GRID_EN draws a green dot grid on empty pixels.
module bounce_engine
  import bounce_pkg::*;
#(
  parameter int NUM_BALLS = 4,
  parameter int SCREEN_W  = 128,
  parameter int SCREEN_H  = 160,
  parameter int BALL_SIZE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  output logic [4:0] red,
  output logic [5:0] green,
  output logic [4:0] blue,
  output logic       busy,
  output logic       bounce,
  output logic       overrun
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_BALLS - 1);

  // Storage is always 8 deep so a 3-bit index never runs off the end.
  pos_t x_q  [8];
  pos_t y_q  [8];
  vel_t vx_q [8];
  vel_t vy_q [8];

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       vsync_q, rise;
  logic       any_refl_q, any_refl_d;
  logic       bounce_q, bounce_d;
  logic       overrun_q;
  logic [15:0] rgb_q, rgb_d;

  pos_t nx, ny;
  vel_t nvx, nvy;
  logic refl_x, refl_y;

  assign rise = vsync & ~vsync_q;
  assign busy = (state_q == ST_UPDATE);

  bounce_axis #(.LIMIT(SCREEN_W), .BALL_SIZE(BALL_SIZE)) u_axis_x (
    .pos(x_q[idx_q]), .vel(vx_q[idx_q]), .pos_next(nx), .vel_next(nvx), .reflect(refl_x)
  );

  bounce_axis #(.LIMIT(SCREEN_H), .BALL_SIZE(BALL_SIZE)) u_axis_y (
    .pos(y_q[idx_q]), .vel(vy_q[idx_q]), .pos_next(ny), .vel_next(nvy), .reflect(refl_y)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    any_refl_d = any_refl_q;
    bounce_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d    = ST_UPDATE;
          idx_d      = '0;
          any_refl_d = 1'b0;
        end
      end
      ST_UPDATE: begin
        any_refl_d = any_refl_q | refl_x | refl_y;
        if (idx_q == LAST_IDX) begin
          state_d  = ST_IDLE;
          bounce_d = any_refl_d;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      vsync_q    <= 1'b0;
      any_refl_q <= 1'b0;
      bounce_q   <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        x_q[i]  <= init_x(i);
        y_q[i]  <= init_y(i);
        vx_q[i] <= init_vx(i);
        vy_q[i] <= init_vy(i);
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      vsync_q    <= vsync;
      any_refl_q <= any_refl_d;
      bounce_q   <= bounce_d;
      overrun_q  <= overrun_q | (rise & busy);
      if (state_q == ST_UPDATE) begin
        x_q[idx_q]  <= nx;
        y_q[idx_q]  <= ny;
        vx_q[idx_q] <= nvx;
        vy_q[idx_q] <= nvy;
      end
    end
  end

  // Walk from the highest index down so the lowest overlapping ball wins.
  always_comb begin
    logic [8:0] dx, dy;
    logic       hit;
    rgb_d = '0;
    hit   = 1'b0;
    dx    = '0;
    dy    = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      dx = hpos - x_q[i];
      dy = vpos - y_q[i];
      if (dx < 9'(BALL_SIZE) && dy < 9'(BALL_SIZE)) begin
        hit   = 1'b1;
        rgb_d = colour_of(3'(i));
      end
    end
`ifdef BOUNCE_ENGINE_GRID_EN
    if (!hit && hpos[2:0] == 3'd0 && vpos[2:0] == 3'd0)
      rgb_d = 16'h07E0;
`else
    if (!hit)
      rgb_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign red     = rgb_q[15:11];
  assign green   = rgb_q[10:5];
  assign blue    = rgb_q[4:0];
  assign bounce  = bounce_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_bounce_engine.sv
// Randomised frame/pixel stimulus against a plain-arithmetic ball model with a pixel scoreboard.
module tb_bounce_engine;

  localparam int N  = 4;
  localparam int W  = 128;
  localparam int H  = 160;
  localparam int BS = 4;

  localparam logic [15:0] COL [8] = '{
    16'hF800, 16'h07E0, 16'h001F, 16'hFFE0,
    16'hF81F, 16'h07FF, 16'hFFFF, 16'hFD20
  };

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic [8:0] hpos = '0;
  logic [8:0] vpos = '0;
  logic [4:0] red;
  logic [5:0] green;
  logic [4:0] blue;
  logic       busy, bounce, overrun;

  bounce_engine #(.NUM_BALLS(N), .SCREEN_W(W), .SCREEN_H(H), .BALL_SIZE(BS)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .hpos(hpos), .vpos(vpos),
    .red(red), .green(green), .blue(blue),
    .busy(busy), .bounce(bounce), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic        probe_en = 1'b0;
  logic        probe_d  = 1'b0;

  int  mx [N];
  int  my [N];
  int  mvx[N];
  int  mvy[N];
  bit  exp_ovr;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = 8 + 12 * i;
      my[i]  = 8 + 16 * i;
      mvx[i] = (i % 2 == 0) ? 2 : -1;
      mvy[i] = (i % 2 == 0) ? 1 : -2;
    end
    exp_ovr = 1'b0;
  endtask

  task automatic axis_step(inout int p, inout int v, input int lim, inout bit r);
    int nxt;
    nxt = p + v;
    if (nxt <= 0) begin
      p = 0; v = -v; r = 1'b1;
    end else if (nxt >= lim - BS) begin
      p = lim - BS; v = -v; r = 1'b1;
    end else begin
      p = nxt;
    end
  endtask

  function automatic logic [15:0] model_pixel(input int h, input int v);
    int dx, dy;
    for (int i = 0; i < N; i++) begin
      dx = (h - mx[i]) & 511;
      dy = (v - my[i]) & 511;
      if (dx < BS && dy < BS) return COL[i];
    end
`ifdef BOUNCE_ENGINE_GRID_EN
    if (h % 8 == 0 && v % 8 == 0) return 16'h07E0;
`endif
    return 16'h0000;
  endfunction

  // Monitor: a probe issued in cycle k produces RGB after the next edge.
  always @(posedge clk) probe_d <= probe_en;

  always @(negedge clk) begin
    if (probe_d) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pixel_queue: got output with empty queue at %0t", $time);
      end else begin
        check("pixel", {red, green, blue}, exp_q.pop_front());
      end
    end
  end

  task automatic do_probe(input int h, input int v);
    @(posedge clk);
    #1;
    hpos     = 9'(h & 511);
    vpos     = 9'(v & 511);
    probe_en = 1'b1;
    exp_q.push_back(model_pixel(h & 511, v & 511));
  endtask

  task automatic end_probes();
    @(posedge clk);
    #1;
    probe_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic probe_balls();
    for (int i = 0; i < N; i++) begin
      do_probe(mx[i], my[i]);
      do_probe(mx[i] + BS - 1, my[i] + BS - 1);
      do_probe(mx[i] - 1, my[i]);
      do_probe(mx[i] + BS, my[i] + BS - 1);
      do_probe(mx[i], my[i] - 1);
      do_probe(mx[i] + BS - 1, my[i] + BS);
      do_probe(mx[i] + int'($urandom_range(0, 7)) - 2, my[i] + int'($urandom_range(0, 7)) - 2);
    end
    do_probe(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)));
    do_probe(16, 24);
    end_probes();
  endtask

  task automatic run_frame(input bit ovr_mode);
    bit refl;
    int hold;
    refl = 1'b0;
    for (int i = 0; i < N; i++) begin
      axis_step(mx[i], mvx[i], W, refl);
      axis_step(my[i], mvy[i], H, refl);
    end
    if (ovr_mode) exp_ovr = 1'b1;
    hold = ovr_mode ? 5 : int'($urandom_range(1, 8));
    @(posedge clk);
    #1;
    vsync = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("busy", {15'd0, busy}, {15'd0, (c >= 1 && c <= N)});
      check("bounce", {15'd0, bounce}, {15'd0, (c == N + 1) ? refl : 1'b0});
      if (c == 7) check("overrun", {15'd0, overrun}, {15'd0, exp_ovr});
      if (ovr_mode && c == 1) vsync = 1'b0;
      if (ovr_mode && c == 2) vsync = 1'b1;
      if (c == hold) vsync = 1'b0;
    end
    vsync = 1'b0;
  endtask

  task automatic reset_mid_update();
    @(posedge clk);
    #1;
    vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_bounce", {15'd0, bounce}, 16'd0);
    check("rst_overrun", {15'd0, overrun}, 16'd0);
    check("rst_rgb", {red, green, blue}, 16'd0);
    vsync = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("init_busy", {15'd0, busy}, 16'd0);
    check("init_bounce", {15'd0, bounce}, 16'd0);
    check("init_overrun", {15'd0, overrun}, 16'd0);
    check("init_rgb", {red, green, blue}, 16'd0);
    reset = 1'b0;
    probe_balls();

    for (int f = 0; f < 260; f++) begin
      if (f == 170) reset_mid_update();
      run_frame(f == 30 || f == 120);
      probe_balls();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pixel_drain: %0d pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
